serial_tx_shifter: RTL and testbench

- Transmit datapath of the serial port, directly downstream of serial_tx_control.
- Consumes that FSM's load, shift and stop-bit strobes and serialises SBUF onto TXD, LSB first.
- Returns the end-of-frame strobe that serial_tx_control takes as serial_end_bit_i.
- Frames by 8051 mode: mode 0 = 8 data bits with shift clock; mode 1 = start + 8 + stop; modes 2/3 = start + 8 + TB8 + stop.

---
 rtl/serial_tx_shifter_pkg.sv | 24 ++
 rtl/serial_tx_shifter_if.sv | 38 +++
 rtl/serial_tx_shifter_frame_builder.sv | 51 +++++
 rtl/serial_tx_shifter.sv | 122 ++++++++++++
 tb/tb_serial_tx_shifter.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/serial_tx_shifter_pkg.sv
// Shared constants for the serial transmit shifter: 8051 mode codes,
// frame lengths, shift FSM states and the idle line level.
package serial_pkg;

    typedef enum logic [1:0] {
        MODE0 = 2'b00,
        MODE1 = 2'b01,
        MODE2 = 2'b10,
        MODE3 = 2'b11
    } mode_e;

    localparam int FRAME_LEN_M0  = 8;
    localparam int FRAME_LEN_M1  = 10;
    localparam int FRAME_LEN_M23 = 11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        STOP  = 2'b10
    } state_e;

    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/serial_tx_shifter_if.sv
// Control/status bundle between serial_tx_control (master) and the
// transmit shifter (slave).
interface serial_tx_shifter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 4
);
    import serial_pkg::*;

    logic                  serial_scon7_sm0_i;
    logic                  serial_scon6_sm1_i;
    logic                  serial_scon3_tb8_i;
    logic [DATA_WIDTH-1:0] serial_sbuf_i;
    logic                  serial_start_shifter_reg_i;
    logic                  serial_shift_i;
    logic                  serial_stop_bit_gen_i;
    logic                  serial_txd_o;
    logic                  serial_txclk_o;
    logic                  serial_end_bit_o;
    logic                  serial_busy_o;
    logic [CNT_WIDTH-1:0]  serial_bit_cnt_o;

    modport master (
        output serial_scon7_sm0_i, serial_scon6_sm1_i, serial_scon3_tb8_i,
        output serial_sbuf_i, serial_start_shifter_reg_i, serial_shift_i,
        output serial_stop_bit_gen_i,
        input  serial_txd_o, serial_txclk_o, serial_end_bit_o,
        input  serial_busy_o, serial_bit_cnt_o
    );

    modport slave (
        input  serial_scon7_sm0_i, serial_scon6_sm1_i, serial_scon3_tb8_i,
        input  serial_sbuf_i, serial_start_shifter_reg_i, serial_shift_i,
        input  serial_stop_bit_gen_i,
        output serial_txd_o, serial_txclk_o, serial_end_bit_o,
        output serial_busy_o, serial_bit_cnt_o
    );

endinterface

// File: rtl/serial_tx_shifter_frame_builder.sv
// Combinational frame builder: mode, ninth bit and data -> load vector and
// frame length. Define SERIAL_TX_PARITY_EN to send data parity as bit nine.
module serial_tx_frame_builder
    import serial_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 4
) (
    input  mode_e                 mode,
    input  logic                  tb8,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [DATA_WIDTH+2:0] load_vec,
    output logic [CNT_WIDTH-1:0]  frame_len
);

    localparam int LEN0  = DATA_WIDTH + FRAME_LEN_M0 - 8;
    localparam int LEN1  = DATA_WIDTH + FRAME_LEN_M1 - 8;
    localparam int LEN23 = DATA_WIDTH + FRAME_LEN_M23 - 8;

    logic ninth;

`ifdef SERIAL_TX_PARITY_EN
    logic unused_tb8;
    assign unused_tb8 = tb8;
    assign ninth      = ^data;
`else
    assign ninth = tb8;
`endif

    // Bits above the frame stay 1 so an over-shift still looks like idle.
    always_comb begin
        load_vec  = '1;
        frame_len = CNT_WIDTH'(LEN0);
        unique case (mode)
            MODE0: begin
                load_vec[DATA_WIDTH-1:0] = data;
                frame_len                = CNT_WIDTH'(LEN0);
            end
            MODE1: begin
                load_vec[DATA_WIDTH:0] = {data, 1'b0};
                frame_len              = CNT_WIDTH'(LEN1);
            end
            MODE2, MODE3: begin
                load_vec[DATA_WIDTH+1:0] = {ninth, data, 1'b0};
                frame_len                = CNT_WIDTH'(LEN23);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/serial_tx_shifter.sv
// Serial port transmit datapath: loads SBUF on the load strobe and
// serialises it LSB first on TXD. Optional macro: SERIAL_TX_PARITY_EN.
module serial_tx_shifter
    import serial_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 4
) (
    input logic                serial_clock_i,
    input logic                serial_reset_i,
    serial_tx_shifter_if.slave bus
);

    localparam int SHW = DATA_WIDTH + 3;

    if ((2 ** CNT_WIDTH) <= SHW) begin : g_cnt_check
        $error("CNT_WIDTH too small for DATA_WIDTH");
    end

    mode_e                mode;
    logic [SHW-1:0]       load_vec;
    logic [CNT_WIDTH-1:0] len_new;

    state_e               state, state_d;
    logic [SHW-1:0]       shreg, shreg_d;
    logic [CNT_WIDTH-1:0] cnt, cnt_d;
    logic [CNT_WIDTH-1:0] len, len_d;
    logic                 m0, m0_d;
    logic                 busy, busy_d;
    logic                 txd, txd_d;
    logic                 txclk, txclk_d;
    logic                 end_bit, end_d;

    assign mode = mode_e'({bus.serial_scon7_sm0_i, bus.serial_scon6_sm1_i});

    serial_tx_frame_builder #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_builder (
        .mode      (mode),
        .tb8       (bus.serial_scon3_tb8_i),
        .data      (bus.serial_sbuf_i),
        .load_vec  (load_vec),
        .frame_len (len_new)
    );

    always_ff @(posedge serial_clock_i or posedge serial_reset_i) begin
        if (serial_reset_i) begin
            state   <= IDLE;
            shreg   <= '1;
            cnt     <= '0;
            len     <= '0;
            m0      <= 1'b0;
            busy    <= 1'b0;
            txd     <= IDLE_LEVEL;
            txclk   <= 1'b1;
            end_bit <= 1'b0;
        end else begin
            state   <= state_d;
            shreg   <= shreg_d;
            cnt     <= cnt_d;
            len     <= len_d;
            m0      <= m0_d;
            busy    <= busy_d;
            txd     <= txd_d;
            txclk   <= txclk_d;
            end_bit <= end_d;
        end
    end

    always_comb begin
        state_d = state;
        shreg_d = shreg;
        cnt_d   = cnt;
        len_d   = len;
        m0_d    = m0;
        busy_d  = busy;
        txd_d   = txd;
        txclk_d = 1'b1;
        end_d   = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.serial_start_shifter_reg_i) begin
                    shreg_d = load_vec;
                    cnt_d   = '0;
                    len_d   = len_new;
                    m0_d    = (mode == MODE0);
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.serial_shift_i) begin
                    txd_d   = shreg[0];
                    shreg_d = {1'b1, shreg[SHW-1:1]};
                    cnt_d   = cnt + 1'b1;
                    txclk_d = !m0;
                    if ((cnt + 1'b1) == len) state_d = STOP;
                end
            end
            STOP: begin
                // Last bit has been held a full bit time; close the frame.
                if (bus.serial_shift_i) begin
                    end_d   = 1'b1;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    txd_d   = IDLE_LEVEL;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (bus.serial_stop_bit_gen_i) txd_d = IDLE_LEVEL;
    end

    assign bus.serial_txd_o     = txd;
    assign bus.serial_txclk_o   = txclk;
    assign bus.serial_end_bit_o = end_bit;
    assign bus.serial_busy_o    = busy;
    assign bus.serial_bit_cnt_o = cnt;

endmodule

// File: tb/tb_serial_tx_shifter.sv
// Self-checking bench for serial_tx_shifter: directed frames per mode plus
// randomized frames against a bit-list reference model.
module tb_serial_tx_shifter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    serial_tx_shifter_if #(.DATA_WIDTH(8), .CNT_WIDTH(4)) bus ();

    serial_tx_shifter #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut (
        .serial_clock_i (clk),
        .serial_reset_i (rst),
        .bus            (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] status();
        return {bus.serial_txd_o, bus.serial_txclk_o, bus.serial_end_bit_o,
                bus.serial_busy_o, bus.serial_bit_cnt_o};
    endfunction

    // Loads one frame, then issues N+1 shift strobes with random gaps and
    // checks every cycle against the expected bit list.
    task automatic run_frame(input logic [1:0] mode, input logic [7:0] data,
                             input logic tb8, input int gap_max,
                             input int frc_a, input int frc_b,
                             input bit reload4, input bit shift_on_load,
                             input string name);
        bit         q[$];
        int         n;
        logic       ninth;
        logic       exp_txd;
        logic [7:0] exp;
        logic [7:0] obs;
`ifdef SERIAL_TX_PARITY_EN
        ninth = ^data;
`else
        ninth = tb8;
`endif
        q = {};
        if (mode != 2'd0) q.push_back(1'b0);
        for (int i = 0; i < 8; i++) q.push_back(data[i]);
        if (mode[1]) q.push_back(ninth);
        if (mode != 2'd0) q.push_back(1'b1);
        n = q.size();

        bus.serial_scon7_sm0_i         = mode[1];
        bus.serial_scon6_sm1_i         = mode[0];
        bus.serial_scon3_tb8_i         = tb8;
        bus.serial_sbuf_i              = data;
        bus.serial_start_shifter_reg_i = 1'b1;
        bus.serial_shift_i             = shift_on_load;
        tick();
        bus.serial_start_shifter_reg_i = 1'b0;
        bus.serial_shift_i             = 1'b0;
        {bus.serial_scon7_sm0_i, bus.serial_scon6_sm1_i,
         bus.serial_scon3_tb8_i} = 3'($urandom);
        bus.serial_sbuf_i = 8'($urandom);

        obs = status();
        exp = {1'b1, 1'b1, 1'b0, 1'b1, 4'd0};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s load: status=%h expected=%h", name, obs, exp);
        end

        exp_txd = 1'b1;
        for (int k = 1; k <= n + 1; k++) begin
            if (k == frc_a) bus.serial_stop_bit_gen_i = 1'b1;
            bus.serial_shift_i = 1'b1;
            if (reload4 && k == 4) begin
                bus.serial_start_shifter_reg_i = 1'b1;
                bus.serial_sbuf_i              = 8'hFF;
            end
            tick();
            bus.serial_shift_i             = 1'b0;
            bus.serial_start_shifter_reg_i = 1'b0;
            if (k == frc_b) bus.serial_stop_bit_gen_i = 1'b0;

            if (k >= frc_a && k <= frc_b) exp_txd = 1'b1;
            else if (k <= n)              exp_txd = q[k-1];
            else                          exp_txd = 1'b1;
            exp = {exp_txd, !(mode == 2'd0 && k <= n), k == n + 1, k <= n,
                   (k <= n) ? 4'(k) : 4'd0};
            obs = status();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL %s strobe %0d: status=%h expected=%h",
                         name, k, obs, exp);
            end

            exp[6] = 1'b1;
            exp[5] = 1'b0;
            repeat ($urandom_range(gap_max, 1)) begin
                tick();
                obs = status();
                checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("FAIL %s gap after %0d: status=%h expected=%h",
                             name, k, obs, exp);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (status() !== 8'b1100_0000) begin
            errors++;
            $display("FAIL reset: status=%h expected=%h", status(), 8'hC0);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_shift_idle();
        bus.serial_shift_i = 1'b1;
        tick();
        bus.serial_shift_i = 1'b0;
        tick();
        checks++;
        if (status() !== 8'b1100_0000) begin
            errors++;
            $display("FAIL shift_idle: status=%h expected=%h", status(), 8'hC0);
        end
    endtask

    task automatic test_modes();
        run_frame(2'd1, 8'hA5, 1'b0, 2, 0, 0, 1'b0, 1'b0, "mode1_a5");
        run_frame(2'd2, 8'h3C, 1'b1, 2, 0, 0, 1'b0, 1'b0, "mode2_3c");
        run_frame(2'd2, 8'h3D, 1'b0, 3, 0, 0, 1'b0, 1'b0, "mode2_3d");
        run_frame(2'd3, 8'h96, 1'b1, 1, 0, 0, 1'b0, 1'b0, "mode3_96");
        run_frame(2'd0, 8'h81, 1'b0, 2, 0, 0, 1'b0, 1'b0, "mode0_81");
    endtask

    task automatic test_load_while_busy();
        run_frame(2'd1, 8'h5A, 1'b0, 2, 0, 0, 1'b1, 1'b0, "load_busy");
    endtask

    task automatic test_stop_bit_gen();
        run_frame(2'd1, 8'h00, 1'b0, 3, 2, 3, 1'b0, 1'b0, "stop_gen");
    endtask

    task automatic test_load_with_shift();
        run_frame(2'd1, 8'hC3, 1'b0, 1, 0, 0, 1'b0, 1'b1, "load_shift");
    endtask

    task automatic test_reset_mid_frame();
        bus.serial_scon7_sm0_i         = 1'b0;
        bus.serial_scon6_sm1_i         = 1'b1;
        bus.serial_sbuf_i              = 8'h0F;
        bus.serial_start_shifter_reg_i = 1'b1;
        tick();
        bus.serial_start_shifter_reg_i = 1'b0;
        repeat (4) begin
            bus.serial_shift_i = 1'b1;
            tick();
            bus.serial_shift_i = 1'b0;
            tick();
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (status() !== 8'b1100_0000) begin
            errors++;
            $display("FAIL reset_async: status=%h expected=%h", status(), 8'hC0);
        end
        tick();
        checks++;
        if (status() !== 8'b1100_0000) begin
            errors++;
            $display("FAIL reset_edge: status=%h expected=%h", status(), 8'hC0);
        end
        rst = 1'b0;
        tick();
        run_frame(2'd1, 8'h55, 1'b0, 2, 0, 0, 1'b0, 1'b0, "after_reset");
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++)
            run_frame(2'($urandom), 8'($urandom), 1'($urandom), 3, 0, 0,
                      1'b0, 1'b0, "random");
    endtask

    initial begin
        bus.serial_scon7_sm0_i         = 1'b0;
        bus.serial_scon6_sm1_i         = 1'b0;
        bus.serial_scon3_tb8_i         = 1'b0;
        bus.serial_sbuf_i              = 8'h00;
        bus.serial_start_shifter_reg_i = 1'b0;
        bus.serial_shift_i             = 1'b0;
        bus.serial_stop_bit_gen_i      = 1'b0;
        test_reset();
        test_shift_idle();
        test_modes();
        test_load_while_busy();
        test_stop_bit_gen();
        test_load_with_shift();
        test_reset_mid_frame();
        test_random();
        test_shift_idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
